fifo_drain_arbiter: RTL
=======================

Name: fifo_drain_arbiter

Overview:
- Read-domain controller that shares one downstream TX serializer between two async FIFOs (channel 0, channel 1).
- Watches each FIFO's empty flag, pops one word at a time via that FIFO's read-increment, registers the word and offers it to the serializer with a valid/ready handshake.
- Round-robin arbitration with a bounded burst length per grant; instantiated once per read clock domain, directly on the FIFO read ports.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and tx_data.
- BURST_LEN, 4, max consecutive words from one channel while the other is non-empty; legal range 1..15.

Ports:
- CLK  in  1  read-domain clock.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  arbiter enable; when low no new pop is started.
- ch0_empty  in  1  FIFO 0 empty flag.
- ch0_rd_data  in  DATA_WIDTH  FIFO 0 read data, combinational from its read address.
- ch0_r_inc  out  1  FIFO 0 read increment, one-cycle pulse.
- ch1_empty  in  1  FIFO 1 empty flag.
- ch1_rd_data  in  DATA_WIDTH  FIFO 1 read data.
- ch1_r_inc  out  1  FIFO 1 read increment.
- tx_data  out  DATA_WIDTH  registered word to serializer.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  serializer accepts when tx_valid and tx_ready are both high at a CLK edge.
- grant  out  1  channel currently or last granted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, RST=1): state=IDLE, tx_data=0, tx_valid=0, ch0_r_inc=ch1_r_inc=0, grant=1 (so ch0 wins first contention), burst_cnt=0, busy=0.
- States: IDLE, POP, SEND.
- IDLE:
  - If EN=1 and at least one channel is non-empty, select a channel and go to POP; burst_cnt=0.
  - Selection: only one non-empty → that channel. Both non-empty → the channel != grant.
  - grant is updated at this transition.
- POP, exactly one cycle:
  - chN_r_inc=1 for the granted channel only; r_inc is a combinational decode of state==POP and grant.
  - At the edge: tx_data<=chN_rd_data, tx_valid<=1, next state SEND.
- SEND: tx_valid held at 1 and tx_data stable until accepted. On the acceptance edge:
  - tx_valid<=0.
  - Let n = burst_cnt+1.
  - Granted channel non-empty and (n < BURST_LEN or other channel empty) → POP, same grant. burst_cnt<=n, or 0 if n==BURST_LEN (burst restarts while uncontended).
  - Otherwise → IDLE. IDLE then grants the other channel if it is non-empty.
  - If EN=0 at acceptance → IDLE regardless.
- Empty flags are sampled in SEND, never in POP. The post-pop empty update (one cycle after r_inc) is therefore always seen, and the block never pops an empty FIFO.
- Latency: IDLE with data → tx_valid high 2 edges later. Sustained one channel with tx_ready=1: one word per 2 cycles.
- EN falling mid-operation: the current POP/SEND completes; no word is dropped or duplicated.
- At most one r_inc is high in any cycle. r_inc is never high outside POP.
- RST asserted mid-SEND: the in-flight word is discarded. The FIFO has already advanced, so data loss is accepted on reset.

Test Plan:
- Reset: RST=1 with both FIFOs holding data → all outputs at reset values, no r_inc. Release RST, EN=1 → ch0 popped first; tx_valid rises 2 cycles after IDLE sees data.
- Single channel: ch1 holds 0x11,0x22,0x33, ch0 empty, tx_ready=1 → tx_data sequence 0x11,0x22,0x33; ch1_r_inc pulses exactly 3 times, every 2 cycles; ch0_r_inc never high; ends in IDLE with busy=0.
- Contention with BURST_LEN=4: ch0 holds 10 words, ch1 holds 10 words → output order 4×ch0, 4×ch1, 4×ch0, 4×ch1, 2×ch0, 2×ch1; no word lost or duplicated, per-channel order preserved.
- Backpressure: tx_ready=0 for 7 cycles during SEND → tx_data/tx_valid stable for all 7 cycles, no r_inc. Raise tx_ready → one transfer, then the next POP.
- Last word: ch0 holds 1 word, ch1 holds 3 words → ch0 word, then 3 ch1 words; empty is re-read in SEND and no pop occurs on the empty ch0.
- EN and reset: deassert EN during SEND → word completes, then IDLE with both FIFOs still non-empty and no further r_inc. Assert RST mid-SEND → tx_valid drops immediately (async).

Source files
------------

// File: rtl/fifo_drain_arbiter.sv
// Drains two read-domain FIFOs one word at a time into a shared TX serializer,
// alternating channels round-robin with a bounded burst per grant.
//
// state | meaning
// IDLE  | waiting for EN and a non-empty channel; picks the next grant
// POP   | one-cycle read increment on the granted FIFO, captures its word
// SEND  | tx_valid held until the serializer accepts; decides next pop
module fifo_drain_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  ch0_empty,
    input  logic [DATA_WIDTH-1:0] ch0_rd_data,
    output logic                  ch0_r_inc,
    input  logic                  ch1_empty,
    input  logic [DATA_WIDTH-1:0] ch1_rd_data,
    output logic                  ch1_r_inc,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  grant,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [4:0] BURST_MAX = 5'(BURST_LEN);

    state_t     state;
    logic [3:0] burst_cnt;
    logic [4:0] burst_nxt;
    logic       cur_empty;
    logic       other_empty;
    logic       keep_going;

    assign burst_nxt   = {1'b0, burst_cnt} + 5'd1;
    assign cur_empty   = grant ? ch1_empty : ch0_empty;
    assign other_empty = grant ? ch0_empty : ch1_empty;
    // Stay on the channel while under the burst limit, or indefinitely if uncontended.
    assign keep_going  = EN && !cur_empty && ((burst_nxt < BURST_MAX) || other_empty);

    assign ch0_r_inc = (state == POP) && !grant;
    assign ch1_r_inc = (state == POP) &&  grant;
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            grant     <= 1'b1;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (EN && (!ch0_empty || !ch1_empty)) begin
                        if (!ch0_empty && !ch1_empty)
                            grant <= ~grant;
                        else
                            grant <= ch0_empty;
                        burst_cnt <= '0;
                        state     <= POP;
                    end
                end
                POP: begin
                    tx_data  <= grant ? ch1_rd_data : ch0_rd_data;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (keep_going) begin
                            burst_cnt <= (burst_nxt == BURST_MAX) ? 4'd0 : burst_nxt[3:0];
                            state     <= POP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
